// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and PC sequencing for a multi-cycle core.
// Fetches one word per instruction, holds it while the datapath executes,
// then steps the PC by the selected source (next / branch / jump / register).
//
// Ports:
//   CLK, RST      clock and synchronous active-high reset
//   ihit, iload   instruction memory handshake and returned word
//   iREN, iaddr   instruction read request and address (always pc)
//   instruction   latched instruction word for the control unit
//   instr_valid   instruction holds a fetched word awaiting execution
//   advance       datapath finished the current instruction
//   PCSrc         next-PC select: 0 NEXT, 1 BRANCH, 2 JUMP, 3 REG
//   imm16         branch offset in words
//   load_addr     absolute jump target
//   reg_target    register-file value used as the JR target
//   halt, halted  HALT decoded / sticky stopped indication
//   pc, pc_plus4  current PC and its link value
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        advance,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] imm16,
    input  logic [31:0] load_addr,
    input  logic [31:0] reg_target,
    input  logic        halt,
    output logic        halted,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned SEL_W  = 2;

    localparam logic [SEL_W-1:0] SRC_NEXT   = SEL_W'(0);
    localparam logic [SEL_W-1:0] SRC_BRANCH = SEL_W'(1);
    localparam logic [SEL_W-1:0] SRC_JUMP   = SEL_W'(2);
    localparam logic [SEL_W-1:0] SRC_REG    = SEL_W'(3);

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        EXEC   = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] pc_nxt;
    logic [WORD_W-1:0] instruction_nxt;
    logic [WORD_W-1:0] next_pc;
    logic [WORD_W-1:0] branch_off;

    // Word offset sign-extended and scaled to bytes.
    assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};
    assign pc_plus4   = pc + WORD_W'(4);

    // Next-PC select; all arithmetic wraps modulo 2^32.
    always_comb begin
        next_pc = pc_plus4;
        case (PCSrc)
            SRC_NEXT:   next_pc = pc_plus4;
            SRC_BRANCH: next_pc = pc_plus4 + branch_off;
            SRC_JUMP:   next_pc = load_addr;
            SRC_REG:    next_pc = reg_target;
            default:    next_pc = pc_plus4;
        endcase
    end

    // State, PC and instruction registers; reset overrides everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= FETCH;
            pc          <= PC_INIT;
            instruction <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instruction <= instruction_nxt;
        end
    end

    // Next-state logic; halt beats advance in EXEC.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        instruction_nxt = instruction;
        case (state)
            FETCH: begin
                if (ihit) begin
                    instruction_nxt = iload;
                    state_nxt       = EXEC;
                end
            end
            EXEC: begin
                if (halt) begin
                    state_nxt = HALTED;
                end else if (advance) begin
                    pc_nxt    = next_pc;
                    state_nxt = FETCH;
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Status outputs decoded from the state register only.
    assign iREN        = (state == FETCH);
    assign instr_valid = (state == EXEC);
    assign halted      = (state == HALTED);
    assign iaddr       = pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_INIT, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port ihit, input, 1 bit: instruction memory has returned iload for the current request.
REQ-005 The block SHALL have port iload, input, 32 bits (word_t): instruction word from memory.
REQ-006 The block SHALL have port iREN, output, 1 bit: instruction read request.
REQ-007 The block SHALL have port iaddr, output, 32 bits: fetch address, always equal to pc.
REQ-008 The block SHALL have port instruction, output, 32 bits: latched instruction presented to the control unit.
REQ-009 The block SHALL have port instr_valid, output, 1 bit: instruction holds a fetched word awaiting execution.
REQ-010 The block SHALL have port advance, input, 1 bit: the datapath has completed the current instruction (including any data-memory access).
REQ-011 The block SHALL have port PCSrc, input, 2 bits (pc_mux_input_selection), with values NEXT, BRANCH, JUMP and REG.
REQ-012 The block SHALL have port imm16, input, 16 bits: branch offset from the control unit.
REQ-013 The block SHALL have port load_addr, input, 32 bits: complete jump target from the control unit.
REQ-014 The block SHALL have port reg_target, input, 32 bits: register-file value used as the JR target.
REQ-015 The block SHALL have port halt, input, 1 bit: the control unit has decoded HALT.
REQ-016 The block SHALL have port halted, output, 1 bit: sticky indication that the processor has stopped.
REQ-017 The block SHALL have port pc, output, 32 bits: current PC.
REQ-018 The block SHALL have port pc_plus4, output, 32 bits: pc + 4, used as the JAL link value.

Function
REQ-019 The block SHALL implement a state machine with states FETCH, EXEC and HALTED.
REQ-020 FETCH SHALL drive iREN=1 and instr_valid=0; on ihit=1 at an edge, instruction <= iload and the state SHALL become EXEC.
REQ-021 EXEC SHALL drive iREN=0 and instr_valid=1; instruction SHALL hold stable, and ihit SHALL be ignored.
REQ-022 In EXEC with advance=1 and halt=0, at the edge pc <= next_pc and the state SHALL become FETCH.
REQ-023 next_pc SHALL be selected by PCSrc as follows:
- NEXT: pc+4.
- BRANCH: pc+4 + (sign-extended imm16 << 2).
- JUMP: load_addr.
- REG: reg_target.
REQ-024 All PC arithmetic SHALL be modulo 2^32, with no overflow detection; for example, 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-025 In EXEC with halt=1, at the next edge the state SHALL become HALTED regardless of advance, and pc SHALL NOT update; halt takes priority over advance.
REQ-026 HALTED SHALL drive iREN=0, instr_valid=0 and halted=1; the block SHALL leave HALTED only on reset.
REQ-027 advance in FETCH and advance/halt in HALTED SHALL be ignored.
REQ-028 In FETCH, ihit=1 in the first cycle SHALL be accepted, giving a minimum of 2 cycles per instruction: one FETCH cycle and one EXEC cycle.
REQ-029 Latency SHALL be as follows:
- ihit sampled at edge k gives instr_valid=1 with the new instruction from cycle k+1.
- advance sampled at edge m gives iREN=1 with iaddr=next_pc from cycle m+1.
REQ-030 iREN, instr_valid and halted SHALL be decoded from the state register only, with no combinational path from any input.

Reset
REQ-031 When RST=1 at a rising edge, the block SHALL set state=FETCH, pc=PC_INIT, instruction=0 and halted=0, with priority over every other input.
REQ-032 The outputs after the reset edge SHALL be iREN=1, iaddr=PC_INIT, instr_valid=0 and pc_plus4=PC_INIT+4.
REQ-033 Reset asserted mid-fetch (FETCH with ihit pending) or in EXEC/HALTED SHALL discard the pending instruction, and a simultaneous ihit SHALL NOT be latched.

Verification
REQ-034 Reset, then ihit=1 with iload=32'h2001_0005 after 3 wait cycles -> iREN=1 with iaddr=0 for those 3 cycles, then instruction=32'h2001_0005 and instr_valid=1.
REQ-035 EXEC at pc=32'h0000_0010 with PCSrc=BRANCH, imm16=16'hFFFC and advance=1 -> next iaddr=32'h0000_0004; with imm16=16'h0003 -> 32'h0000_0020.
REQ-036 EXEC with PCSrc=JUMP, load_addr=32'h0000_0100 -> iaddr=32'h0000_0100; with PCSrc=REG, reg_target=32'h0000_0040 -> iaddr=32'h0000_0040.
REQ-037 EXEC at pc=32'hFFFF_FFFC with PCSrc=NEXT and advance=1 -> pc=32'h0000_0000, and pc_plus4 before the edge = 32'h0000_0000.
REQ-038 EXEC with halt=1 and advance=1 together -> halted=1 and iREN=0 with pc unchanged; ihit and advance are then ignored for 10 cycles; RST=1 -> halted=0 and iaddr=PC_INIT.
REQ-039 RST=1 in the same cycle as ihit=1 in FETCH -> instruction=0 and instr_valid=0 after the edge.
